// File: rtl/wb_slave_mem_pkg.sv
// wb_pkg: shared types and defaults for the Wishbone slave memory block.
//   DATA_WL / ADR_WL : default data and address bus widths
//   CNT_W / cnt_t    : wait-state counter width (wait states 0..15)
//   state_e          : one-hot controller states IDLE / WAIT / ACK
package wb_pkg;

  localparam int DATA_WL = 16;
  localparam int ADR_WL  = 16;
  localparam int CNT_W   = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    WAIT = 3'b010,
    ACK  = 3'b100
  } state_e;

endpackage

// File: rtl/wb_slave_mem_if.sv
// wb_slave_mem_if: Wishbone classic bus between the chip master and the slave memory.
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i : master -> slave request
//   wb_dat_o, wb_ack_o                              : slave -> master response
//   wb_err_o                                        : range error, only when
//                                                     WB_SLV_RANGE_CHK_EN is defined
// Modports: master (drives requests), slave (drives responses).
interface wb_slave_mem_if import wb_pkg::*; #(
  parameter int data_wl = DATA_WL,
  parameter int adr_wl  = ADR_WL
);

  logic               wb_cyc_i;
  logic               wb_stb_i;
  logic               wb_we_i;
  logic [adr_wl-1:0]  wb_adr_i;
  logic [data_wl-1:0] wb_dat_i;
  logic [data_wl-1:0] wb_dat_o;
  logic               wb_ack_o;
`ifdef WB_SLV_RANGE_CHK_EN
  logic               wb_err_o;

  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  input  wb_dat_o, wb_ack_o, wb_err_o);
  modport slave  (input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  output wb_dat_o, wb_ack_o, wb_err_o);
`else
  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  output wb_dat_o, wb_ack_o);
`endif

endinterface

// File: rtl/wb_slave_mem_ram.sv
// wb_slv_ram: synchronous single-port RAM, 2**mem_aw words of data_wl bits.
//   clk   : rising-edge clock
//   we    : write wdata to mem[addr]
//   re    : capture mem[addr] into rdata; rdata holds otherwise
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (not reset; contents undefined until written)
module wb_slv_ram #(
  parameter int data_wl = 16,
  parameter int mem_aw  = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [mem_aw-1:0]  addr,
  input  logic [data_wl-1:0] wdata,
  output logic [data_wl-1:0] rdata
);

  logic [data_wl-1:0] mem [2**mem_aw];
  logic [data_wl-1:0] rdata_q;

  // Plain RAM template with no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic slave with on-chip RAM, programmable wait
// states, doorbell interrupt and per-transaction sync pulse.
//   clk        : rising-edge clock
//   a_reset_l  : asynchronous active-low reset
//   wb         : Wishbone slave modport (cyc/stb/we/adr/dat in, dat/ack out)
//   intr_h     : doorbell interrupt level, set by a write to doorbell_adr
//   intr_ack_h : clears intr_h (a simultaneous set wins)
//   sync_h     : one-cycle pulse together with wb_ack_o
// Optional macro WB_SLV_RANGE_CHK_EN: adds wb_err_o; accesses with nonzero
// upper address bits are acknowledged with an error and do not touch RAM.
module wb_slave_mem import wb_pkg::*; #(
  parameter int                data_wl      = DATA_WL,
  parameter int                adr_wl       = ADR_WL,
  parameter int                mem_aw       = 8,
  parameter int                wait_cycles  = 2,
  parameter logic [adr_wl-1:0] doorbell_adr = 'h00FF
) (
  input  logic          clk,
  input  logic          a_reset_l,
  wb_slave_mem_if.slave wb,
  output logic          intr_h,
  input  logic          intr_ack_h,
  output logic          sync_h
);

  state_e             state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [adr_wl-1:0]  adr_q, adr_d;
  logic [data_wl-1:0] dat_q, dat_d;
  logic               ack_q, ack_d;
  logic               sync_q, sync_d;
  logic               intr_q, intr_d;
  logic               dat_sel_q, dat_sel_d;
  logic               err_q, err_d;
  logic               in_range;
  logic               ram_we, ram_re;
  logic               db_set;
  logic [data_wl-1:0] ram_rdata;

`ifdef WB_SLV_RANGE_CHK_EN
  assign in_range = (adr_q[adr_wl-1:mem_aw] == '0);
`else
  assign in_range = 1'b1;
`endif

  wb_slv_ram #(.data_wl(data_wl), .mem_aw(mem_aw)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (adr_q[mem_aw-1:0]),
    .wdata (dat_q),
    .rdata (ram_rdata)
  );

  // Controller: latch the request in IDLE, count wait states, and on the
  // WAIT->ACK edge commit the RAM access and raise ack/sync for one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    dat_sel_d = dat_sel_q;
    ack_d     = 1'b0;
    sync_d    = 1'b0;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    db_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          we_d    = wb.wb_we_i;
          adr_d   = wb.wb_adr_i;
          dat_d   = wb.wb_dat_i;
          cnt_d   = cnt_t'(wait_cycles);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          sync_d  = 1'b1;
          err_d   = ~in_range;
          if (we_q) begin
            ram_we = in_range;
            db_set = in_range && (adr_q == doorbell_adr);
          end else begin
            ram_re    = in_range;
            // Out-of-range reads present zero instead of RAM data.
            dat_sel_d = in_range;
          end
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Doorbell level: a set on the same edge as a clear takes priority.
  always_comb begin
    intr_d = intr_q;
    if (db_set)          intr_d = 1'b1;
    else if (intr_ack_h) intr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      sync_q    <= 1'b0;
      intr_q    <= 1'b0;
      dat_sel_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      sync_q    <= sync_d;
      intr_q    <= intr_d;
      dat_sel_q <= dat_sel_d;
      err_q     <= err_d;
    end
  end

  // The RAM read register holds across writes; dat_sel_q masks it to zero
  // after reset and after an out-of-range read.
  assign wb.wb_dat_o = dat_sel_q ? ram_rdata : '0;
  assign wb.wb_ack_o = ack_q;
  assign sync_h      = sync_q;
  assign intr_h      = intr_q;
`ifdef WB_SLV_RANGE_CHK_EN
  assign wb.wb_err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
// Testbench for wb_slave_mem: one instance with 2 wait states (dut2) and one
// with 0 wait states (dut0), both fed from the same request signals.
module tb_wb_slave_mem;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [15:0] adr = '0, dat = '0;
  logic        intr_ack = 1'b0;
  logic        intr2, intr0, sync2, sync0;
  int          checks = 0;
  int          errors = 0;

  wb_slave_mem_if bus2 ();
  wb_slave_mem_if bus0 ();

  assign bus2.wb_cyc_i = cyc;
  assign bus2.wb_stb_i = stb;
  assign bus2.wb_we_i  = we;
  assign bus2.wb_adr_i = adr;
  assign bus2.wb_dat_i = dat;
  assign bus0.wb_cyc_i = cyc;
  assign bus0.wb_stb_i = stb;
  assign bus0.wb_we_i  = we;
  assign bus0.wb_adr_i = adr;
  assign bus0.wb_dat_i = dat;

  wb_slave_mem #(.wait_cycles(2)) dut2 (
    .clk(clk), .a_reset_l(rst_n), .wb(bus2),
    .intr_h(intr2), .intr_ack_h(intr_ack), .sync_h(sync2));

  wb_slave_mem #(.wait_cycles(0)) dut0 (
    .clk(clk), .a_reset_l(rst_n), .wb(bus0),
    .intr_h(intr0), .intr_ack_h(intr_ack), .sync_h(sync0));

  always #5 clk = ~clk;

  // One single-beat request; lat = number of edges from the request edge to
  // the edge that raised ack (-1 if no ack within the budget).
  task automatic do_req(input bit sel0, input bit w, input logic [15:0] a,
                        input logic [15:0] d, output int lat,
                        output logic [15:0] rdat, output logic intr,
                        output logic err);
    lat = -1; rdat = '0; intr = 1'b0; err = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel0 ? bus0.wb_ack_o : bus2.wb_ack_o) begin
        lat  = n;
        rdat = sel0 ? bus0.wb_dat_o : bus2.wb_dat_o;
        intr = sel0 ? intr0 : intr2;
`ifdef WB_SLV_RANGE_CHK_EN
        err  = sel0 ? bus0.wb_err_o : bus2.wb_err_o;
`endif
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (bus2.wb_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 0", bus2.wb_ack_o); end
    checks++; if (bus2.wb_dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dat got %h want 0000", bus2.wb_dat_o); end
    checks++; if (intr2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_intr got %b want 0", intr2); end
    checks++; if (sync2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync got %b want 0", sync2); end
    checks++; if (bus0.wb_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack0 got %b want 0", bus0.wb_ack_o); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_wait_states();
    int lat; logic [15:0] rd; logic it, er;
    do_req(1'b0, 1'b1, 16'h0010, 16'hA5A5, lat, rd, it, er);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL write_latency got %0d want 3", lat); end
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, it, er);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL read_latency got %0d want 3", lat); end
    checks++; if (rd !== 16'hA5A5) begin errors++; $display("[TB] FAIL read_data got %h want a5a5", rd); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus2.wb_dat_o !== 16'hA5A5) begin errors++; $display("[TB] FAIL read_hold%0d got %h want a5a5", i, bus2.wb_dat_o); end
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0; int lat; logic [15:0] rd; logic it, er;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0040; dat = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    if (bus0.wb_ack_o) acks++;
    adr = 16'h0044; dat = 16'h2222;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus0.wb_ack_o) acks++;
    end
    checks++; if (acks !== 1) begin errors++; $display("[TB] FAIL b2b_ack_count got %0d want 1", acks); end
    do_req(1'b1, 1'b0, 16'h0040, 16'h0000, lat, rd, it, er);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL reissue_latency got %0d want 1", lat); end
    checks++; if (rd !== 16'h1111) begin errors++; $display("[TB] FAIL reissue_data got %h want 1111", rd); end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_doorbell();
    int lat; logic [15:0] rd; logic it, er;
    do_req(1'b0, 1'b1, 16'h00FF, 16'h1234, lat, rd, it, er);
    checks++; if (it !== 1'b1) begin errors++; $display("[TB] FAIL db_intr_at_ack got %b want 1", it); end
    do_req(1'b0, 1'b0, 16'h00FF, 16'h0000, lat, rd, it, er);
    checks++; if (rd !== 16'h1234) begin errors++; $display("[TB] FAIL db_read got %h want 1234", rd); end
    @(negedge clk) intr_ack = 1'b1;
    @(posedge clk); #1 intr_ack = 1'b0;
    @(negedge clk);
    checks++; if (intr2 !== 1'b0) begin errors++; $display("[TB] FAIL db_clear got %b want 0", intr2); end
    // clear asserted exactly on the doorbell write's completing edge
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h00FF; dat = 16'h4321;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) intr_ack = 1'b1;
    @(posedge clk); #1 intr_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus2.wb_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL db_set_ack got %b want 1", bus2.wb_ack_o); end
    checks++; if (intr2 !== 1'b1) begin errors++; $display("[TB] FAIL db_set_wins got %b want 1", intr2); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int lat; int acks = 0; logic [15:0] rd; logic it, er;
    do_req(1'b0, 1'b1, 16'h0020, 16'h0000, lat, rd, it, er);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0020; dat = 16'hBEEF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if (bus2.wb_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_ack got %b want 0", bus2.wb_ack_o); end
    checks++; if (bus2.wb_dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL abort_dat got %h want 0000", bus2.wb_dat_o); end
    checks++; if (intr2 !== 1'b0) begin errors++; $display("[TB] FAIL abort_intr got %b want 0", intr2); end
    checks++; if (sync2 !== 1'b0) begin errors++; $display("[TB] FAIL abort_sync got %b want 0", sync2); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus2.wb_ack_o) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL abort_no_ack got %0d want 0", acks); end
    do_req(1'b0, 1'b0, 16'h0020, 16'h0000, lat, rd, it, er);
    checks++; if (rd !== 16'h0000) begin errors++; $display("[TB] FAIL abort_not_committed got %h want 0000", rd); end
  endtask

  task automatic test_alias_range();
    int lat; logic [15:0] rd; logic it, er;
`ifdef WB_SLV_RANGE_CHK_EN
    do_req(1'b0, 1'b1, 16'h0005, 16'h0A0A, lat, rd, it, er);
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL inrange_err got %b want 0", er); end
    do_req(1'b0, 1'b1, 16'h0105, 16'h5555, lat, rd, it, er);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL range_err got %b want 1", er); end
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL range_latency got %0d want 3", lat); end
    do_req(1'b0, 1'b0, 16'h0005, 16'h0000, lat, rd, it, er);
    checks++; if (rd !== 16'h0A0A) begin errors++; $display("[TB] FAIL range_unchanged got %h want 0a0a", rd); end
`else
    do_req(1'b0, 1'b1, 16'h0105, 16'h5555, lat, rd, it, er);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL alias_latency got %0d want 3", lat); end
    do_req(1'b0, 1'b0, 16'h0005, 16'h0000, lat, rd, it, er);
    checks++; if (rd !== 16'h5555) begin errors++; $display("[TB] FAIL alias_read got %h want 5555", rd); end
`endif
  endtask

  task automatic test_sync();
    int acks = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0010; dat = 16'h0000;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (sync2 !== bus2.wb_ack_o) begin errors++; $display("[TB] FAIL sync_cycle%0d got %b want %b", i, sync2, bus2.wb_ack_o); end
      if (bus2.wb_ack_o === 1'b1) acks++;
    end
    checks++; if (acks !== 1) begin errors++; $display("[TB] FAIL sync_ack_width got %0d want 1", acks); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_back_to_back();
    test_doorbell();
    test_reset_abort();
    test_alias_range();
    test_sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
